// File: rtl/iiitb_piso_stream.sv
// iiitb_piso_stream
//   Parallel-in serial-out shifter with a valid/ready input handshake and
//   framed serial output. It accepts one WIDTH-bit word per handshake and
//   emits it one bit per clock, either LSB-first or MSB-first. A word
//   accepted in the last-bit cycle of the current frame follows it with no
//   idle cycle.
//
//   Optional build macro: IIITB_PISO_PARITY_EN
//     When defined, an even-parity bit (XOR of the accepted word) is
//     appended after the last data bit. The frame is then WIDTH+1 bits long,
//     and frame_end and the gapless-accept window both move to the parity
//     cycle. When undefined, the frame carries the data bits only.
//
// Parameters
//   WIDTH     : parallel word width, 2..64
//   MSB_FIRST : 0 = shift LSB first, 1 = shift MSB first
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous reset, active-high
//   data_in     in   parallel word, sampled on an accepted handshake
//   in_valid    in   data_in is valid
//   in_ready    out  a word can be accepted this cycle (combinational)
//   ser_out     out  serial data bit, 0 when no frame bit is shown
//   ser_valid   out  ser_out carries a frame bit
//   frame_start out  first bit of a frame
//   frame_end   out  last bit of a frame
//   busy        out  a frame is being shifted (same as ser_valid)
module iiitb_piso_stream #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

`ifdef IIITB_PISO_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CNT_W = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             frame_end_q, frame_end_d;
    logic             busy_q;
`ifdef IIITB_PISO_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic             last_bit;
    logic             accept;

    // Bit that leaves the word next, in the configured shift order.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    // The word with its head bit removed. The freed position fills with 0.
    function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
    endfunction

    // The counter holds the number of frame bits still to follow the one
    // currently on ser_out, so 0 marks the last-bit cycle.
    assign last_bit = (state_q == SHIFT) && (cnt_q == '0);
    assign in_ready = !rst && ((state_q == IDLE) || last_bit);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        cnt_d         = cnt_q;
        ser_out_d     = 1'b0;
        ser_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
`ifdef IIITB_PISO_PARITY_EN
        parity_d      = parity_q;
`endif

        if (accept) begin
            // The first bit goes straight to the output register. The shift
            // register keeps only the bits that are still to be sent.
            state_d       = SHIFT;
            cnt_d         = CNT_LOAD;
            ser_out_d     = head_bit(data_in);
            shreg_d       = drop_head(data_in);
            ser_valid_d   = 1'b1;
            frame_start_d = 1'b1;
`ifdef IIITB_PISO_PARITY_EN
            parity_d      = ^data_in;
`endif
        end else if (state_q == SHIFT) begin
            if (last_bit) begin
                state_d = IDLE;
            end else begin
                cnt_d       = cnt_q - CNT_ONE;
                ser_valid_d = 1'b1;
                frame_end_d = (cnt_q == CNT_ONE);
                ser_out_d   = head_bit(shreg_q);
                shreg_d     = drop_head(shreg_q);
`ifdef IIITB_PISO_PARITY_EN
                // With parity, the final cycle sends the stored parity
                // instead of a data bit.
                if (cnt_q == CNT_ONE) begin
                    ser_out_d = parity_q;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            cnt_q         <= '0;
            ser_out_q     <= 1'b0;
            ser_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            busy_q        <= 1'b0;
`ifdef IIITB_PISO_PARITY_EN
            parity_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            cnt_q         <= cnt_d;
            ser_out_q     <= ser_out_d;
            ser_valid_q   <= ser_valid_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            busy_q        <= ser_valid_d;
`ifdef IIITB_PISO_PARITY_EN
            parity_q      <= parity_d;
`endif
        end
    end

    assign ser_out     = ser_out_q;
    assign ser_valid   = ser_valid_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_iiitb_piso_stream.sv
module tb_iiitb_piso_stream;

    localparam int WIDTH = 8;
`ifdef IIITB_PISO_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] data_in;
    logic             in_valid;

    logic in_ready_l, ser_out_l, ser_valid_l, frame_start_l, frame_end_l, busy_l;
    logic in_ready_m, ser_out_m, ser_valid_m, frame_start_m, frame_end_m, busy_m;

    iiitb_piso_stream #(.WIDTH(WIDTH), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid),
        .in_ready(in_ready_l), .ser_out(ser_out_l), .ser_valid(ser_valid_l),
        .frame_start(frame_start_l), .frame_end(frame_end_l), .busy(busy_l)
    );

    iiitb_piso_stream #(.WIDTH(WIDTH), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid),
        .in_ready(in_ready_m), .ser_out(ser_out_m), .ser_valid(ser_valid_m),
        .frame_start(frame_start_m), .frame_end(frame_end_m), .busy(busy_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic v;
        logic b;
        logic s;
        logic e;
    } exp_t;

    exp_t ql[$];
    exp_t qm[$];
    exp_t cur_l, cur_m;
    int   n_checks;
    int   n_fail;
    int   n_acc;

    function automatic logic model_ready();
        return !rst && (!cur_l.v || cur_l.e);
    endfunction

    // {in_ready, ser_out, ser_valid, frame_start, frame_end, busy}
    function automatic logic [5:0] exp_vec(input exp_t e);
        return {model_ready(), e.v & e.b, e.v, e.s, e.e, e.v};
    endfunction

    function automatic void push_frame(input logic [WIDTH-1:0] d);
        exp_t el, em;
        for (int i = 0; i < WIDTH; i++) begin
            el.v = 1'b1; el.b = d[i];           el.s = (i == 0); el.e = (i == FRAME_LEN - 1);
            em.v = 1'b1; em.b = d[WIDTH-1-i];   em.s = (i == 0); em.e = (i == FRAME_LEN - 1);
            ql.push_back(el);
            qm.push_back(em);
        end
`ifdef IIITB_PISO_PARITY_EN
        el.v = 1'b1; el.b = ^d; el.s = 1'b0; el.e = 1'b1;
        ql.push_back(el);
        qm.push_back(el);
`endif
    endfunction

    // Clocks one cycle and updates the reference model; it performs no comparison.
    task automatic advance();
        logic acc;
        acc = in_valid && model_ready();
        if (rst) begin
            ql.delete();
            qm.delete();
        end else if (acc) begin
            push_frame(data_in);
            n_acc++;
        end
        @(posedge clk);
        if (rst) begin
            cur_l = '0;
            cur_m = '0;
        end else begin
            cur_l = (ql.size() > 0) ? ql.pop_front() : exp_t'('0);
            cur_m = (qm.size() > 0) ? qm.pop_front() : exp_t'('0);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; data_in = 8'hA5;
        for (int c = 0; c < 3; c++) begin
            advance();
            n_checks++;
            if ({in_ready_l, ser_out_l, ser_valid_l, frame_start_l, frame_end_l, busy_l,
                 in_ready_m, ser_out_m, ser_valid_m, frame_start_m, frame_end_m, busy_m}
                !== {6'b0, 6'b0}) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d: got lsb=%b msb=%b required all 0", c,
                         {in_ready_l, ser_out_l, ser_valid_l, frame_start_l, frame_end_l, busy_l},
                         {in_ready_m, ser_out_m, ser_valid_m, frame_start_m, frame_end_m, busy_m});
            end
        end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        n_checks++;
        if ({in_ready_l, in_ready_m} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b required 11", {in_ready_l, in_ready_m});
        end
    endtask

    task automatic test_single_frame();
        logic [WIDTH-1:0] sl, sm;
        int k;
        sl = '0; sm = '0; k = 0;
        data_in = 8'h1D; in_valid = 1'b1;
        for (int c = 0; c < FRAME_LEN + 3; c++) begin
            advance();
            in_valid = 1'b0;
            data_in = 8'h66;
            if (ser_valid_l && k < WIDTH) begin
                sl[k] = ser_out_l;
                sm[k] = ser_out_m;
                k++;
            end
            n_checks++;
            if ({in_ready_l, ser_out_l, ser_valid_l, frame_start_l, frame_end_l, busy_l,
                 in_ready_m, ser_out_m, ser_valid_m, frame_start_m, frame_end_m, busy_m}
                !== {exp_vec(cur_l), exp_vec(cur_m)}) begin
                n_fail++;
                $display("FAIL single_frame cycle %0d: got %b required %b", c + 1,
                         {in_ready_l, ser_out_l, ser_valid_l, frame_start_l, frame_end_l, busy_l,
                          in_ready_m, ser_out_m, ser_valid_m, frame_start_m, frame_end_m, busy_m},
                         {exp_vec(cur_l), exp_vec(cur_m)});
            end
        end
        // Stream bit k is the value shown in cycle k+1.
        n_checks++;
        if (sl !== 8'h1D) begin
            n_fail++;
            $display("FAIL lsb_stream_1D: got %h required 1d", sl);
        end
        n_checks++;
        if (sm !== 8'hB8) begin
            n_fail++;
            $display("FAIL msb_stream_1D: got %h required b8", sm);
        end
    endtask

    task automatic test_back_to_back();
        int run, max_run, start_acc;
        run = 0; max_run = 0; start_acc = n_acc;
        data_in = 8'h1D; in_valid = 1'b1;
        for (int c = 0; c < 2 * FRAME_LEN + 4; c++) begin
            advance();
            // After the first word is taken, offer the second one until it is taken.
            if (n_acc - start_acc == 1) data_in = 8'hFF;
            if (n_acc - start_acc >= 2) begin
                in_valid = 1'b0;
                data_in = 8'h00;
            end
            run = ser_valid_l ? run + 1 : 0;
            if (run > max_run) max_run = run;
            n_checks++;
            if ({in_ready_l, ser_out_l, ser_valid_l, frame_start_l, frame_end_l, busy_l,
                 in_ready_m, ser_out_m, ser_valid_m, frame_start_m, frame_end_m, busy_m}
                !== {exp_vec(cur_l), exp_vec(cur_m)}) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d: got %b required %b", c + 1,
                         {in_ready_l, ser_out_l, ser_valid_l, frame_start_l, frame_end_l, busy_l,
                          in_ready_m, ser_out_m, ser_valid_m, frame_start_m, frame_end_m, busy_m},
                         {exp_vec(cur_l), exp_vec(cur_m)});
            end
        end
        n_checks++;
        if (max_run !== 2 * FRAME_LEN) begin
            n_fail++;
            $display("FAIL back_to_back_gapless: got run %0d required %0d", max_run, 2 * FRAME_LEN);
        end
    endtask

    task automatic test_midframe_reset();
        data_in = 8'hFF; in_valid = 1'b1;
        for (int c = 0; c < 2 * FRAME_LEN + 8; c++) begin
            if (c == 1) in_valid = 1'b0;
            if (c == 3) rst = 1'b1;
            if (c == 4) rst = 1'b0;
            if (c == 6) begin
                data_in = 8'h01;
                in_valid = 1'b1;
            end
            if (c == 7) in_valid = 1'b0;
            advance();
            n_checks++;
            if ({in_ready_l, ser_out_l, ser_valid_l, frame_start_l, frame_end_l, busy_l,
                 in_ready_m, ser_out_m, ser_valid_m, frame_start_m, frame_end_m, busy_m}
                !== {exp_vec(cur_l), exp_vec(cur_m)}) begin
                n_fail++;
                $display("FAIL midframe_reset cycle %0d: got %b required %b", c + 1,
                         {in_ready_l, ser_out_l, ser_valid_l, frame_start_l, frame_end_l, busy_l,
                          in_ready_m, ser_out_m, ser_valid_m, frame_start_m, frame_end_m, busy_m},
                         {exp_vec(cur_l), exp_vec(cur_m)});
            end
        end
    endtask

    task automatic test_parity_words();
        logic [WIDTH-1:0] words [4];
        int wi;
        words[0] = 8'h0B; words[1] = 8'h1D; words[2] = 8'h80; words[3] = 8'h00;
        wi = 0;
        in_valid = 1'b1; data_in = words[0];
        for (int c = 0; c < 4 * FRAME_LEN + 6; c++) begin
            advance();
            if (n_acc > 0 && wi < 4 && !in_valid) begin
                in_valid = 1'b1;
            end
            // A new word is presented once the previous one has been taken.
            if (wi < 4 && model_ready() && in_valid && cur_l.e) begin
                // in the last-bit cycle: keep data for this accept
            end
            if (c == 0) begin wi = 1; data_in = words[1]; end
            if (c == FRAME_LEN) begin wi = 2; data_in = words[2]; end
            if (c == 2 * FRAME_LEN) begin wi = 3; data_in = words[3]; end
            if (c == 3 * FRAME_LEN) begin wi = 4; in_valid = 1'b0; end
            n_checks++;
            if ({in_ready_l, ser_out_l, ser_valid_l, frame_start_l, frame_end_l, busy_l,
                 in_ready_m, ser_out_m, ser_valid_m, frame_start_m, frame_end_m, busy_m}
                !== {exp_vec(cur_l), exp_vec(cur_m)}) begin
                n_fail++;
                $display("FAIL words cycle %0d: got %b required %b", c + 1,
                         {in_ready_l, ser_out_l, ser_valid_l, frame_start_l, frame_end_l, busy_l,
                          in_ready_m, ser_out_m, ser_valid_m, frame_start_m, frame_end_m, busy_m},
                         {exp_vec(cur_l), exp_vec(cur_m)});
            end
        end
    endtask

    task automatic test_random_traffic();
        for (int c = 0; c < 300; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            data_in  = WIDTH'($urandom);
            advance();
            n_checks++;
            if ({in_ready_l, ser_out_l, ser_valid_l, frame_start_l, frame_end_l, busy_l,
                 in_ready_m, ser_out_m, ser_valid_m, frame_start_m, frame_end_m, busy_m}
                !== {exp_vec(cur_l), exp_vec(cur_m)}) begin
                n_fail++;
                $display("FAIL random cycle %0d: got %b required %b", c,
                         {in_ready_l, ser_out_l, ser_valid_l, frame_start_l, frame_end_l, busy_l,
                          in_ready_m, ser_out_m, ser_valid_m, frame_start_m, frame_end_m, busy_m},
                         {exp_vec(cur_l), exp_vec(cur_m)});
            end
        end
        in_valid = 1'b0;
        for (int c = 0; c < FRAME_LEN + 2; c++) advance();
        n_checks++;
        if (ser_valid_l !== 1'b0 || ser_valid_m !== 1'b0 || ql.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got ser_valid %b%b pending %0d required 00 and 0",
                     ser_valid_l, ser_valid_m, ql.size());
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; n_acc = 0;
        cur_l = '0; cur_m = '0;
        rst = 1'b1; in_valid = 1'b0; data_in = '0;
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_midframe_reset();
        test_parity_words();
        test_random_traffic();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iiitb_piso_stream.md
Name: iiitb_piso_stream

Overview:
Parametrised parallel-in serial-out shifter with a valid/ready input handshake and framed serial output. Accepts one WIDTH-bit word per handshake and emits it one bit per clock, LSB- or MSB-first. Frame start/end markers are provided for downstream serial links. Back-to-back words are serialised with no idle gap. Successor to the fixed 8-bit load/shift PISO.

Parameters:
WIDTH, 8, parallel word width in bits; legal range 2..64.
MSB_FIRST, 0, 0 = shift LSB first; 1 = shift MSB first.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous reset, active-high.
data_in  input  WIDTH  parallel word, sampled on an accepted handshake.
in_valid  input  1  data_in is valid.
in_ready  output  1  block can accept a word this cycle (combinational).
ser_out  output  1  serial data bit (registered).
ser_valid  output  1  ser_out carries a frame bit (registered).
frame_start  output  1  high with the first bit of a frame (registered).
frame_end  output  1  high with the last bit of a frame (registered).
busy  output  1  a frame is being shifted (registered; equals ser_valid).

Behaviour:
- Interface: one clock and a synchronous, active-high reset; clock port clk, reset port rst.
- Reset (rst=1 at a clk edge): state=IDLE; shift register, bit counter, ser_out, ser_valid, frame_start, frame_end and busy all clear to 0. in_ready is forced to 0 while rst=1. Reset mid-frame aborts the frame; the remaining bits are discarded.
- Accept: a word is accepted at an edge where in_valid & in_ready. data_in is copied into the shift register; the counter loads FRAME_LEN-1. FRAME_LEN = WIDTH (WIDTH+1 with parity).
- States: IDLE and SHIFT.
  - IDLE -> SHIFT on accept.
  - SHIFT -> SHIFT on the last bit if a new word is accepted.
  - SHIFT -> IDLE on the last bit with no accept.
- Latency: the first bit appears on ser_out in the cycle after the accepting edge, with ser_valid=1 and frame_start=1.
- Each following cycle presents the next bit; frame_start=0. Selected bit is data_in[0] upward when MSB_FIRST=0, data_in[WIDTH-1] downward when MSB_FIRST=1.
- frame_end=1 only in the cycle showing the last frame bit.
- in_ready = !rst & (state==IDLE | last-bit cycle). Accepting on the last-bit cycle yields the next frame's first bit in the very next cycle (gapless). frame_end of frame N and frame_start of frame N+1 are then in adjacent cycles.
- in_valid while in_ready=0: word is not taken. The source must hold it; the block does not latch it.
- ser_out=0 whenever ser_valid=0.
- data_in changes outside the accept edge have no effect on the current frame.
- Counter width: $clog2(WIDTH+2) bits; the counter never wraps below 0.

Optional Feature:
IIITB_PISO_PARITY_EN
- Defined: an even-parity bit (XOR of the accepted word) is appended after the last data bit. FRAME_LEN=WIDTH+1; frame_end moves to the parity cycle; in_ready's last-bit term refers to the parity cycle.
- Undefined: no parity logic; FRAME_LEN=WIDTH; frame is data bits only.

Test Plan:
- Reset: hold rst=1 for 3 cycles with in_valid=1 -> in_ready=0, ser_out=ser_valid=frame_start=frame_end=busy=0; after release in_ready=1.
- LSB-first, WIDTH=8, MSB_FIRST=0, accept 8'h1D at cycle 0 -> cycles 1..8 ser_out=1,0,1,1,1,0,0,0. frame_start at cycle 1, frame_end at cycle 8, in_ready=0 in cycles 1..7, state=IDLE at cycle 9.
- MSB-first, MSB_FIRST=1, accept 8'h1D -> ser_out=0,0,0,1,1,1,0,1, same framing.
- Back-to-back: in_valid held, 8'h1D then 8'hFF -> 16 consecutive ser_valid cycles; frame_end at cycle 8, frame_start at cycle 9, bits 9..16 all 1.
- Mid-frame reset: rst=1 after the 3rd bit of 8'hFF -> all outputs 0 the next cycle. The next accepted 8'h01 produces a clean frame 1,0,0,0,0,0,0,0.
- Parity (macro defined, WIDTH=8): accept 8'h0B -> ser_out=1,1,0,1,0,0,0,0 then parity 1 in cycle 9 with frame_end=1; 8'h1D gives parity 0.
